// File: rtl/pwm_preconditioner.sv
// Converts per-transducer silenced duty/phase plus cycle into PWM rise/fall compare times.
// One pipelined pass over all DEPTH transducers runs after each upstream update burst ends.
//
//   state | meaning
//   IDLE  | waiting for the falling edge of DIN_VALID
//   RUN   | issuing indices 0..DEPTH-1 and draining the 3-stage pipeline
module pwm_preconditioner #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 249
) (
   input  logic                         CLK,
   input  logic                         RST_N,
   input  logic                         DIN_VALID,
   input  logic [DEPTH-1:0][WIDTH-1:0]  CYCLE,
   input  logic [DEPTH-1:0][WIDTH-1:0]  DUTY,
   input  logic [DEPTH-1:0][WIDTH-1:0]  PHASE,
   output logic [DEPTH-1:0][WIDTH-1:0]  RISE,
   output logic [DEPTH-1:0][WIDTH-1:0]  FALL,
   output logic                         DOUT_VALID
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);
   // two guard bits keep P+l and P-h exact for any legal WIDTH-bit operands
   localparam int SW = WIDTH + 2;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state;
   logic              pending;
   logic              din_valid_d;
   logic              issue;
   logic [IW-1:0]     idx;
   logic              start;

   logic              s1_valid;
   logic [IW-1:0]     s1_idx;
   logic [WIDTH-1:0]  s1_t;
   logic [WIDTH-1:0]  s1_dc;
   logic [WIDTH-1:0]  s1_p;

   logic              s2_valid;
   logic [IW-1:0]     s2_idx;
   logic [WIDTH-1:0]  s2_t;
   logic signed [SW-1:0] s2_r;
   logic signed [SW-1:0] s2_f;
   logic              s2_fixed;

   logic              last_write;
   logic [WIDTH-1:0]  half_lo;
   logic [WIDTH-1:0]  half_hi;
   logic signed [SW-1:0] p_s;
   logic signed [SW-1:0] h_s;
   logic signed [SW-1:0] l_s;
   logic signed [SW-1:0] t1_s;
   logic signed [SW-1:0] t2_s;
   logic signed [SW-1:0] nxt_r;
   logic signed [SW-1:0] nxt_f;
   logic              nxt_fixed;
   logic signed [SW-1:0] fold_r;
   logic signed [SW-1:0] fold_f;

   assign start      = din_valid_d & ~DIN_VALID;
   assign last_write = s2_valid && (s2_idx == LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state       <= IDLE;
         pending     <= 1'b0;
         din_valid_d <= 1'b0;
         issue       <= 1'b0;
         idx         <= '0;
         DOUT_VALID  <= 1'b0;
      end else begin
         din_valid_d <= DIN_VALID;
         DOUT_VALID  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  idx   <= '0;
                  issue <= 1'b1;
               end
            end
            RUN: begin
               if (issue) begin
                  if (idx == LAST) issue <= 1'b0;
                  else             idx   <= idx + 1'b1;
               end
               if (start) pending <= 1'b1;
               // a start landing on the return edge itself also triggers the rerun
               if (last_write) begin
                  DOUT_VALID <= 1'b1;
                  if (pending || start) begin
                     idx     <= '0;
                     issue   <= 1'b1;
                     pending <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign half_lo = s1_dc >> 1;
   assign half_hi = s1_dc - half_lo;
   assign p_s     = {2'b00, s1_p};
   assign h_s     = {2'b00, half_lo};
   assign l_s     = {2'b00, half_hi};
   assign t1_s    = {2'b00, s1_t};
   assign t2_s    = {2'b00, s2_t};

   always_comb begin
      nxt_r     = '0;
      nxt_f     = '0;
      nxt_fixed = 1'b1;
      if (s1_t == '0) begin
         nxt_r = '0;
         nxt_f = '0;
      end else if (s1_dc == '0) begin
         nxt_r = p_s;
         nxt_f = p_s;
      end else if (s1_dc == s1_t) begin
         nxt_r = '0;
         nxt_f = t1_s;
      end else begin
         nxt_r     = p_s - h_s;
         nxt_f     = p_s + l_s;
         nxt_fixed = 1'b0;
      end
   end

   always_comb begin
      fold_r = s2_r;
      fold_f = s2_f;
      if (!s2_fixed) begin
         if (s2_r < 0)     fold_r = s2_r + t2_s;
         if (s2_f >= t2_s) fold_f = s2_f - t2_s;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s1_t     <= '0;
         s1_dc    <= '0;
         s1_p     <= '0;
         s2_valid <= 1'b0;
         s2_idx   <= '0;
         s2_t     <= '0;
         s2_r     <= '0;
         s2_f     <= '0;
         s2_fixed <= 1'b1;
      end else begin
         s1_valid <= (state == RUN) && issue;
         s1_idx   <= idx;
         s1_t     <= CYCLE[idx];
         s1_p     <= PHASE[idx];
         s1_dc    <= (DUTY[idx] < CYCLE[idx]) ? DUTY[idx] : CYCLE[idx];
         s2_valid <= s1_valid;
         s2_idx   <= s1_idx;
         s2_t     <= s1_t;
         s2_r     <= nxt_r;
         s2_f     <= nxt_f;
         s2_fixed <= nxt_fixed;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         RISE <= '0;
         FALL <= '0;
      end else if (s2_valid) begin
         RISE[s2_idx] <= fold_r[WIDTH-1:0];
         FALL[s2_idx] <= fold_f[WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_pwm_preconditioner.sv
// Self-checking bench for pwm_preconditioner: directed and random passes against an
// arithmetic reference model, plus completion timing, pending rerun and mid-pass reset.
module tb_pwm_preconditioner;

   localparam int WIDTH = 13;
   localparam int DEPTH = 249;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic din_valid = 1'b0;
   logic [DEPTH-1:0][WIDTH-1:0] cycle;
   logic [DEPTH-1:0][WIDTH-1:0] duty;
   logic [DEPTH-1:0][WIDTH-1:0] phase;
   logic [DEPTH-1:0][WIDTH-1:0] rise;
   logic [DEPTH-1:0][WIDTH-1:0] fall;
   logic dout_valid;

   int n_checks = 0;
   int n_errors = 0;

   int exp_r[8] = '{4046, 3850, 0, 7, 0, 0, 0, 0};
   int exp_f[8] = '{150, 54, 201, 7, 4096, 4096, 0, 200};

   always #5 clk = ~clk;

   pwm_preconditioner #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK        (clk),
      .RST_N      (rst_n),
      .DIN_VALID  (din_valid),
      .CYCLE      (cycle),
      .DUTY       (duty),
      .PHASE      (phase),
      .RISE       (rise),
      .FALL       (fall),
      .DOUT_VALID (dout_valid)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // reference: clamp, split duty around the phase centre, wrap into [0, T)
   function automatic void model(input int t, input int d, input int p,
                                 output int r, output int f);
      int dc, h, l;
      if (t == 0) begin
         r = 0; f = 0;
      end else begin
         dc = (d < t) ? d : t;
         if (dc == 0) begin
            r = p; f = p;
         end else if (dc == t) begin
            r = 0; f = t;
         end else begin
            h = dc / 2;
            l = dc - h;
            r = p - h;
            if (r < 0) r = r + t;
            f = p + l;
            if (f >= t) f = f - t;
         end
      end
   endfunction

   task automatic check_all(input string tag);
      int r, f;
      for (int i = 0; i < DEPTH; i++) begin
         model(int'(cycle[i]), int'(duty[i]), int'(phase[i]), r, f);
         check($sformatf("%s_rise[%0d]", tag, i), int'(rise[i]), r);
         check($sformatf("%s_fall[%0d]", tag, i), int'(fall[i]), f);
      end
   endtask

   task automatic set_all(input int t, input int d, input int p);
      for (int i = 0; i < DEPTH; i++) begin
         cycle[i] = WIDTH'(t);
         duty[i]  = WIDTH'(d);
         phase[i] = WIDTH'(p);
      end
   endtask

   task automatic burst(input int hi);
      @(negedge clk);
      din_valid = 1'b1;
      repeat (hi) @(negedge clk);
      din_valid = 1'b0;
   endtask

   // cycle 1 of the window is the edge that samples the falling DIN_VALID
   task automatic run_pass(input string tag);
      int np, pc;
      np = 0;
      pc = -1;
      burst(5);
      for (int c = 1; c <= DEPTH + 10; c++) begin
         @(posedge clk);
         #1;
         if (dout_valid) begin
            np++;
            if (np == 1) pc = c;
         end
      end
      check({tag, "_pulses"}, np, 1);
      check({tag, "_latency"}, pc, DEPTH + 3);
   endtask

   initial begin
      int np, t, k;
      int pulses[$];

      set_all(4096, 200, 100);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dout_valid", int'(dout_valid), 0);
      check("rst_rise0", int'(rise[0]), 0);
      check("rst_fall_last", int'(fall[DEPTH-1]), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_pass("basic");
      check_all("basic");

      for (int i = 0; i < DEPTH; i++) begin
         k = i % 8;
         cycle[i] = 13'd4096;
         case (k)
            0: begin phase[i] = 13'd50;   duty[i] = 13'd200;  end
            1: begin phase[i] = 13'd4000; duty[i] = 13'd300;  end
            2: begin phase[i] = 13'd100;  duty[i] = 13'd201;  end
            3: begin phase[i] = 13'd7;    duty[i] = 13'd0;    end
            4: begin phase[i] = 13'd100;  duty[i] = 13'd4096; end
            5: begin phase[i] = 13'd100;  duty[i] = 13'd5000; end
            6: begin phase[i] = 13'd0;    duty[i] = 13'd100; cycle[i] = 13'd0; end
            default: begin phase[i] = 13'd100; duty[i] = 13'd200; end
         endcase
      end
      run_pass("dir");
      for (int i = 0; i < DEPTH; i++) begin
         if (i < 8 || i >= DEPTH - 9) begin
            check($sformatf("dir_rise[%0d]", i), int'(rise[i]), exp_r[i % 8]);
            check($sformatf("dir_fall[%0d]", i), int'(fall[i]), exp_f[i % 8]);
         end
      end
      check_all("dir");

      for (int i = 0; i < DEPTH; i++) begin
         cycle[i] = (i % 2 == 0) ? 13'd4000 : 13'd2000;
         phase[i] = 13'd1990;
         duty[i]  = 13'd40;
      end
      run_pass("mixed");
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("mixed_rise[%0d]", i), int'(rise[i]), 1970);
         check($sformatf("mixed_fall[%0d]", i), int'(fall[i]), (i % 2 == 0) ? 2010 : 10);
      end

      for (int n = 0; n < 3; n++) begin
         for (int i = 0; i < DEPTH; i++) begin
            t = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4096));
            cycle[i] = WIDTH'(t);
            phase[i] = (t > 0) ? WIDTH'($urandom_range(0, t - 1)) : '0;
            case ($urandom_range(0, 5))
               0:       duty[i] = '0;
               1:       duty[i] = WIDTH'(t);
               default: duty[i] = WIDTH'($urandom_range(0, t + t / 4 + 1));
            endcase
         end
         run_pass($sformatf("rand%0d", n));
         check_all($sformatf("rand%0d", n));
      end

      set_all(4096, 200, 100);
      burst(5);
      for (int c = 1; c <= 2 * DEPTH + 30; c++) begin
         @(posedge clk);
         #1;
         if (dout_valid) pulses.push_back(c);
         if (c == 90) begin
            din_valid = 1'b1;
            for (int i = 0; i < DEPTH; i++) phase[i] = 13'd300;
         end
         if (c == 100) din_valid = 1'b0;
         if (c == 150) din_valid = 1'b1;
         if (c == 160) din_valid = 1'b0;
      end
      check("pend_pulses", pulses.size(), 2);
      if (pulses.size() >= 1) check("pend_first", pulses[0], DEPTH + 3);
      if (pulses.size() >= 2) check("pend_gap", pulses[1] - pulses[0] + 1, DEPTH + 3);
      check_all("pend");

      set_all(4096, 200, 500);
      burst(5);
      repeat (122) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_dout_valid", int'(dout_valid), 0);
      for (int i = 0; i < DEPTH; i++) begin
         check($sformatf("midrst_rise[%0d]", i), int'(rise[i]), 0);
         check($sformatf("midrst_fall[%0d]", i), int'(fall[i]), 0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      np = 0;
      repeat (DEPTH + 10) begin
         @(posedge clk);
         #1;
         if (dout_valid) np++;
      end
      check("midrst_no_pulse", np, 0);
      run_pass("postrst");
      check_all("postrst");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
